// File: rtl/cmul_share_arb.sv
// cmul_share_arb: round-robin share of one 3-stage Gauss complex multiplier among NREQ requesters.
// Define CMUL_SHARE_ARB_STATS_EN to add per-requester saturating grant counters.
module cmul_share_arb #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a_re,
    input  logic [NREQ*WIDTH-1:0]   req_a_im,
    input  logic [NREQ*WIDTH-1:0]   req_b_re,
    input  logic [NREQ*WIDTH-1:0]   req_b_im,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [2*WIDTH+1:0]      rsp_re,
    output logic [2*WIDTH+1:0]      rsp_im,
    output logic                    busy,
    output logic [1:0]              state
`ifdef CMUL_SHARE_ARB_STATS_EN
   ,input  logic [$clog2(NREQ)-1:0] cnt_sel,
    input  logic                    cnt_clr,
    output logic [15:0]             cnt_out
`endif
);
    localparam int IW = $clog2(NREQ);
    localparam int P  = 2*WIDTH+1;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
    state_t r_state;
    logic [IW-1:0] r_ptr, w_gid, w_idx, r_id0, r_id1, r_id2;
    logic [2:0] r_v;
    logic w_hs;
    logic [NREQ-1:0][WIDTH-1:0] w_ar, w_ai, w_br, w_bi;
    logic [WIDTH-1:0] r_a, r_b, r_c, r_d;
    logic [WIDTH:0] w_scd, w_sab, w_dab;
    logic [P-1:0] r_c1, r_c2, r_c3;
    logic [P:0] r_re, r_im;
    assign w_ar = req_a_re;
    assign w_ai = req_a_im;
    assign w_br = req_b_re;
    assign w_bi = req_b_im;
    assign state = r_state;
    assign busy = (|r_v) || (r_state != IDLE);
    // Scan downward so the last hit is the first valid requester at or after r_ptr.
    always_comb begin
        w_gid = '0;
        w_idx = '0;
        for (int k = NREQ-1; k >= 0; k--) begin
            w_idx = IW'((int'(r_ptr) + k) % NREQ);
            if (req_valid[w_idx]) w_gid = w_idx;
        end
    end
    assign w_hs = en && (r_state != DRAIN) && (|req_valid);
    assign req_ready = w_hs ? NREQ'(1) << w_gid : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_v       <= '0;
            r_id0     <= '0;
            r_id1     <= '0;
            r_id2     <= '0;
            rsp_valid <= '0;
            rsp_re    <= '0;
            rsp_im    <= '0;
        end else begin
            r_state   <= en ? RUN : (r_state == IDLE || !(|r_v)) ? IDLE : DRAIN;
            if (w_hs) r_ptr <= (w_gid == IW'(NREQ-1)) ? '0 : w_gid + IW'(1);
            r_v       <= {r_v[1:0], w_hs};
            r_id0     <= w_gid;
            r_id1     <= r_id0;
            r_id2     <= r_id1;
            rsp_valid <= r_v[2] ? NREQ'(1) << r_id2 : '0;
            if (r_v[2]) begin
                rsp_re <= r_re;
                rsp_im <= r_im;
            end
        end
    end
    // Operands are sign-extended to full product width so every stage is exact.
    assign w_scd = {r_c[WIDTH-1], r_c} + {r_d[WIDTH-1], r_d};
    assign w_sab = {r_a[WIDTH-1], r_a} + {r_b[WIDTH-1], r_b};
    assign w_dab = {r_a[WIDTH-1], r_a} - {r_b[WIDTH-1], r_b};
    always_ff @(posedge clk) begin
        r_a  <= w_ar[w_gid];
        r_b  <= w_ai[w_gid];
        r_c  <= w_br[w_gid];
        r_d  <= w_bi[w_gid];
        r_c1 <= {{(WIDTH+1){r_a[WIDTH-1]}}, r_a} * {{WIDTH{w_scd[WIDTH]}}, w_scd};
        r_c2 <= {{(WIDTH+1){r_d[WIDTH-1]}}, r_d} * {{WIDTH{w_sab[WIDTH]}}, w_sab};
        r_c3 <= {{(WIDTH+1){r_c[WIDTH-1]}}, r_c} * {{WIDTH{w_dab[WIDTH]}}, w_dab};
        r_re <= {r_c1[P-1], r_c1} - {r_c2[P-1], r_c2};
        r_im <= {r_c1[P-1], r_c1} - {r_c3[P-1], r_c3};
    end
`ifdef CMUL_SHARE_ARB_STATS_EN
    logic [NREQ-1:0][15:0] r_cnt;
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_cnt   <= '0;
            cnt_out <= '0;
        end else begin
            for (int k = 0; k < NREQ; k++)
                if (req_valid[k] && req_ready[k] && r_cnt[k] != 16'hFFFF) r_cnt[k] <= r_cnt[k] + 16'd1;
            cnt_out <= r_cnt[cnt_sel];
        end
    end
`endif
endmodule

// File: tb/tb_cmul_share_arb.sv
// tb_cmul_share_arb: scoreboard bench for the shared complex multiplier arbiter.
module tb_cmul_share_arb;
    localparam int W = 16;
    localparam int N = 4;
    logic clk = 0;
    logic rst, en;
    logic [N-1:0] req_valid, req_ready, rsp_valid;
    logic [N*W-1:0] a_re, a_im, b_re, b_im;
    logic [2*W+1:0] rsp_re, rsp_im;
    logic busy;
    logic [1:0] state;
    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    typedef struct {int id; longint re; longint im; int due;} exp_t;
    exp_t q[$];
    int m_ptr = 0;
    int m_state = 0;
    logic [2:0] m_v = '0;
    longint last_re = 0;
    longint last_im = 0;

    cmul_share_arb #(.WIDTH(W), .NREQ(N)) dut (
        .clk(clk), .rst(rst), .en(en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a_re(a_re), .req_a_im(a_im), .req_b_re(b_re), .req_b_im(b_im),
        .rsp_valid(rsp_valid), .rsp_re(rsp_re), .rsp_im(rsp_im),
        .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic longint opv(input logic [N*W-1:0] v, input int i);
        logic [W-1:0] s;
        s = v[i*W +: W];
        return longint'($signed(s));
    endfunction

    // Reference model: evaluated mid-cycle, predicts what the next rising edge does.
    always @(negedge clk) begin
        int g;
        longint ar, ai, br, bi;
        logic [N-1:0] eg;
        g = -1;
        if (en && m_state != 2)
            for (int k = 0; k < N; k++)
                if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        eg = (g < 0) ? '0 : N'(1) << g;
        chk("ready", req_ready, eg);
        chk("state", state, m_state);
        chk("busy", busy, (m_state != 0 || m_v != 0));
        if (rst) begin
            m_state = 0;
            m_ptr = 0;
            m_v = '0;
            q.delete();
            last_re = 0;
            last_im = 0;
        end else begin
            if (g >= 0) begin
                ar = opv(a_re, g);
                ai = opv(a_im, g);
                br = opv(b_re, g);
                bi = opv(b_im, g);
                q.push_back('{g, ar*br - ai*bi, ar*bi + ai*br, cyc + 4});
                m_ptr = (g + 1) % N;
            end
            case (m_state)
                0: if (en) m_state = 1;
                1: if (!en) m_state = (m_v != 0) ? 2 : 0;
                default: if (en) m_state = 1; else if (m_v == 0) m_state = 0;
            endcase
            m_v = {m_v[1:0], g >= 0};
        end
    end

    always @(posedge clk) begin
        exp_t e;
        cyc++;
        #1;
        if (rsp_valid != 0) begin
            if (q.size() == 0) chk("rsp_spurious", rsp_valid, 0);
            else begin
                e = q.pop_front();
                chk("rsp_id", rsp_valid, 1 << e.id);
                chk("rsp_re", $signed(rsp_re), e.re);
                chk("rsp_im", $signed(rsp_im), e.im);
                chk("rsp_cyc", cyc, e.due);
                last_re = e.re;
                last_im = e.im;
            end
        end else begin
            chk("hold_re", $signed(rsp_re), last_re);
            chk("hold_im", $signed(rsp_im), last_im);
            if (q.size() > 0 && q[0].due <= cyc) begin
                chk("rsp_missing", 0, 1);
                void'(q.pop_front());
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic set_op(input int i, input int ar, input int ai, input int br, input int bi);
        a_re[i*W +: W] = W'(ar);
        a_im[i*W +: W] = W'(ai);
        b_re[i*W +: W] = W'(br);
        b_im[i*W +: W] = W'(bi);
    endtask

    function automatic int rnd;
        return ($urandom_range(0, 3) == 0) ? -32768 : int'($urandom_range(0, 65535)) - 32768;
    endfunction

    task automatic rnd_ops;
        for (int i = 0; i < N; i++) set_op(i, rnd(), rnd(), rnd(), rnd());
    endtask

    task automatic do_reset;
        rst = 1;
        tick;
        tick;
        rst = 0;
    endtask

    task automatic wait_rsp(input int n);
        for (int i = 0; i < n && rsp_valid == 0; i++) tick;
        if (rsp_valid == 0) chk("rsp_timeout", 0, 1);
    endtask

    initial begin
        rst = 1;
        en = 0;
        req_valid = '0;
        a_re = '0;
        a_im = '0;
        b_re = '0;
        b_im = '0;
        tick;
        tick;
        rst = 0;
        chk("rst_state", state, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_re", $signed(rsp_re), 0);
        chk("rst_rsp_im", $signed(rsp_im), 0);
        en = 1;
        set_op(0, 3, 4, 5, 6);
        req_valid = 4'b0001;
        tick;
        req_valid = '0;
        wait_rsp(6);
        chk("basic_id", rsp_valid, 1);
        chk("basic_re", $signed(rsp_re), -9);
        chk("basic_im", $signed(rsp_im), 38);
        set_op(2, -32768, -32768, -32768, -32768);
        req_valid = 4'b0100;
        tick;
        req_valid = '0;
        wait_rsp(6);
        chk("min_id", rsp_valid, 4);
        chk("min_re", $signed(rsp_re), 0);
        chk("min_im", $signed(rsp_im), 64'd2147483648);
        set_op(1, 100, -200, 300, -400);
        req_valid = 4'b0010;
        tick;
        req_valid = '0;
        rst = 1;
        tick;
        rst = 0;
        for (int i = 0; i < 5; i++) begin
            chk("rst_no_rsp", rsp_valid, 0);
            tick;
        end
        rnd_ops();
        req_valid = 4'b1010;
        #1;
        chk("rst_ptr_gnt", req_ready, 2);
        tick;
        req_valid = '0;
        do_reset();
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            rnd_ops();
            #1;
            chk("rr_gnt", req_ready, 1 << (k % N));
            tick;
        end
        req_valid = '0;
        for (int k = 0; k < 80; k++) begin
            rnd_ops();
            req_valid = N'($urandom);
            en = ($urandom_range(0, 5) != 0);
            tick;
        end
        req_valid = '0;
        en = 0;
        repeat (6) tick;
        chk("pre_drain_idle", state, 0);
        en = 1;
        rnd_ops();
        req_valid = 4'b0011;
        tick;
        tick;
        en = 0;
        tick;
        chk("drain_state", state, 2);
        chk("drain_ready", req_ready, 0);
        req_valid = '0;
        for (int i = 0; i < 10 && state != 0; i++) tick;
        chk("drain_idle", state, 0);
        chk("drain_busy", busy, 0);
        chk("drain_delivered", q.size(), 0);
        repeat (4) tick;
        chk("sb_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
